// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
//   state_t   : sequencer states (IDLE / RUN / DONE)
//   clog2     : ceiling log2, used to size the bit counter
//   MAX_WIDTH : largest supported operand width
package serial_add_pkg;

    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/F_A.sv
// Single-bit full-adder cell.
//   a, b  : addend bits
//   c_in  : carry in
//   S     : sum bit
//   C     : carry out
module F_A (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic S,
    output logic C
);

    assign S = a ^ b ^ c_in;
    assign C = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one F_A cell is reused for every bit position,
// LSB first, one bit per clock, with the carry held in a register.
//
// Ports:
//   clk, rst_n        : clock (rising edge), async active-low reset
//   start_valid/ready : operand handshake; a, b, c_in sampled on accept
//   res_valid/ready   : result handshake; sum, c_out stable while res_valid
//   busy              : high while an operation is in RUN or DONE
//   ovf               : signed overflow flag (only with SERIAL_ADD_OVF_EN)
//
// Optional feature macro: SERIAL_ADD_OVF_EN adds the ovf output.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    import serial_add_pkg::*;

    localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("serial_add_ctrl: WIDTH out of range");
    end

    state_t           state, nstate;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_c;
    logic             last;

    F_A u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .c_in (carry),
        .S    (fa_s),
        .C    (fa_c)
    );

    assign last = (cnt == LAST);
    // New sum bit enters at the MSB; written this way so WIDTH=1 needs no special case.
    assign sum_nxt = WIDTH'({fa_s, sum_sr} >> 1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    // Next-state logic
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (start_valid) nstate = RUN;
            RUN:     if (last)        nstate = DONE;
            DONE:    if (res_ready)   nstate = IDLE;
            default:                  nstate = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        start_ready = (state == IDLE);
        res_valid   = (state == DONE);
        busy        = (state == RUN) || (state == DONE);
    end

    // Datapath. sum/c_out/ovf are separate registers loaded on the final RUN
    // edge so they hold through DONE and IDLE, even after a new accept
    // reloads carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            c_out  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start_valid) begin
                    a_sr  <= a;
                    b_sr  <= b;
                    carry <= c_in;
                    cnt   <= '0;
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_nxt;
                    carry  <= fa_c;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        sum   <= sum_nxt;
                        c_out <= fa_c;
`ifdef SERIAL_ADD_OVF_EN
                        // On the last bit, carry is the carry into the MSB.
                        ovf   <= carry ^ fa_c;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
